// File: rtl/mips_pkg.sv
// Shared constants and pipeline-register bundles for the MIPS core.
package mips_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          IM_AW_DEFAULT    = 10;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and bubble-insert (flush).
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;
    if_id_t q_d;

    // A flush keeps the fall-through PC but turns the slot into a nop.
    always_comb begin
        q_d = q_q;
        if (!hold_i) begin
            q_d = d_i;
            if (flush_i) begin
                q_d.instr = NOP_INSTR;
                q_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select, IM addressing and
// the IF/ID register, plus sticky fetch-error and fetch counter.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IM_AW      = IM_AW_DEFAULT,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_dout,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             fetch_err,
    output logic [31:0]      instr_cnt
);

    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] off;
    logic [31:0] pc4;
    logic        oor;
    logic        misalign;
    logic        flush;
    logic        load_valid;
    logic        unused_off;

    assign off        = pc_q - RESET_PC;
    assign pc4        = pc_q + 32'd4;
    assign oor        = |off[31:IM_AW+2];
    assign misalign   = |redirect_pc[1:0];
    assign flush      = redirect && !DELAY_SLOT;
    assign load_valid = !stall && !flush;
    assign unused_off = ^off[1:0];

    assign im_addr = off[IM_AW+1:2];

    always_comb begin
        pc_d = pc4;
        if (stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    // Out-of-range fetch flags at the fetch edge; fetch itself aliases on.
    assign err_d = err_q
                 | (!stall && oor)
                 | (!stall && redirect && misalign);

    assign cnt_d = load_valid ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    if_id_t ifid_d;
    if_id_t ifid_q;

    assign ifid_d = '{instr: im_dout, pc4: pc4, valid: 1'b1};

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (stall),
        .flush_i (flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign pc          = pc_q;
    assign if_id_instr = ifid_q.instr;
    assign if_id_pc4   = ifid_q.pc4;
    assign if_id_valid = ifid_q.valid;
    assign fetch_err   = err_q;
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (delay slot on/off) against a
// behavioural fetch model, plus directed literal checks.
module tb_if_stage;

    localparam logic [31:0] RP = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] imem [1024];

    logic [9:0]  ia1, ia0;
    logic [31:0] pc1, pc0, in1, in0, p41, p40, cn1, cn0;
    logic        v1, v0, e1, e0;
    logic [31:0] dout1, dout0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign dout1 = imem[ia1];
    assign dout0 = imem[ia0];

    if_stage #(.RESET_PC(RP), .IM_AW(10), .DELAY_SLOT(1'b1)) u_ds1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .im_addr(ia1), .im_dout(dout1),
        .pc(pc1), .if_id_instr(in1), .if_id_pc4(p41),
        .if_id_valid(v1), .fetch_err(e1), .instr_cnt(cn1)
    );

    if_stage #(.RESET_PC(RP), .IM_AW(10), .DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .im_addr(ia0), .im_dout(dout0),
        .pc(pc0), .if_id_instr(in0), .if_id_pc4(p40),
        .if_id_valid(v0), .fetch_err(e0), .instr_cnt(cn0)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch model: index 0 = delay-slot core, index 1 = squashing core.
    function automatic logic [9:0] wa(input logic [31:0] p);
        logic [31:0] o;
        o = p - RP;
        return o[11:2];
    endfunction

    function automatic bit far(input logic [31:0] p);
        return (p - RP) >= 32'd4096;
    endfunction

    logic [31:0] m_pc [2];
    logic [31:0] m_in [2];
    logic [31:0] m_p4 [2];
    logic [31:0] m_cn [2];
    logic        m_v  [2];
    logic        m_e  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_pc[d] <= RP;
                m_in[d] <= 32'h0;
                m_p4[d] <= 32'h0;
                m_cn[d] <= 32'h0;
                m_v[d]  <= 1'b0;
                m_e[d]  <= 1'b0;
            end else if (!stall) begin
                if (far(m_pc[d]) || (redirect && redirect_pc[1:0] != 2'b00))
                    m_e[d] <= 1'b1;
                m_pc[d] <= redirect ? (redirect_pc & ~32'h3) : m_pc[d] + 32'd4;
                m_p4[d] <= m_pc[d] + 32'd4;
                if (redirect && d == 1) begin
                    m_in[d] <= 32'h0;
                    m_v[d]  <= 1'b0;
                end else begin
                    m_in[d] <= imem[wa(m_pc[d])];
                    m_v[d]  <= 1'b1;
                    m_cn[d] <= m_cn[d] + 32'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("pc1", pc1, m_pc[0]);
        chk("im_addr1", {22'h0, ia1}, {22'h0, wa(m_pc[0])});
        chk("instr1", in1, m_in[0]);
        chk("pc4_1", p41, m_p4[0]);
        chk("valid1", {31'h0, v1}, {31'h0, m_v[0]});
        chk("err1", {31'h0, e1}, {31'h0, m_e[0]});
        chk("cnt1", cn1, m_cn[0]);
        chk("pc0", pc0, m_pc[1]);
        chk("im_addr0", {22'h0, ia0}, {22'h0, wa(m_pc[1])});
        chk("instr0", in0, m_in[1]);
        chk("pc4_0", p40, m_p4[1]);
        chk("valid0", {31'h0, v0}, {31'h0, m_v[1]});
        chk("err0", {31'h0, e0}, {31'h0, m_e[1]});
        chk("cnt0", cn0, m_cn[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'hC0DE_0000 | i;
        #1 rst_n = 1'b0;
        step();
        step();
        chk("L_rst_pc", pc1, 32'h3000);
        chk("L_rst_valid", {31'h0, v1}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("L_e1_instr", in1, 32'hC0DE_0000);
        step();
        chk("L_e2_pc", pc1, 32'h3008);
        chk("L_e2_ia", {22'h0, ia1}, 32'd2);
        chk("L_e2_instr", in1, 32'hC0DE_0001);
        chk("L_e2_pc4", p41, 32'h3008);
        chk("L_e2_cnt", cn1, 32'd2);
        stall = 1'b1;
        step();
        step();
        chk("L_st_pc", pc1, 32'h3008);
        chk("L_st_instr", in1, 32'hC0DE_0001);
        chk("L_st_cnt", cn1, 32'd2);
        stall = 1'b0;
        step();
        chk("L_rs_instr", in1, 32'hC0DE_0002);
        chk("L_rs_pc4", p41, 32'h300C);
        chk("L_rs_cnt", cn1, 32'd3);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h3040;
        step();
        chk("L_rd_pc", pc1, 32'h3040);
        chk("L_rd_ia", {22'h0, ia1}, 32'h10);
        chk("L_ds1_instr", in1, 32'hC0DE_0004);
        chk("L_ds1_valid", {31'h0, v1}, 32'h1);
        chk("L_ds0_instr", in0, 32'h0);
        chk("L_ds0_valid", {31'h0, v0}, 32'h0);
        chk("L_ds0_cnt", cn0, 32'd4);
        redirect = 1'b0;
        step();
        chk("L_tg_instr", in0, 32'hC0DE_0010);
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h3080;
        step();
        chk("L_sr_pc", pc1, 32'h3044);
        stall = 1'b0;
        redirect = 1'b0;
        step();
        chk("L_drop_pc", pc1, 32'h3048);
        redirect = 1'b1;
        step();
        chk("L_take_pc", pc1, 32'h3080);
        redirect_pc = 32'h3042;
        step();
        chk("L_mis_pc", pc1, 32'h3040);
        chk("L_mis_err", {31'h0, e1}, 32'h1);
        redirect = 1'b0;
        step();
        chk("L_mis_sticky", {31'h0, e0}, 32'h1);
        redirect = 1'b1;
        redirect_pc = 32'h4000;
        #2 rst_n = 1'b0;
        #1;
        chk("L_ar_pc", pc1, 32'h3000);
        chk("L_ar_ia", {22'h0, ia0}, 32'h0);
        chk("L_ar_instr", in1, 32'h0);
        chk("L_ar_pc4", p40, 32'h0);
        chk("L_ar_err", {31'h0, e1}, 32'h0);
        chk("L_ar_cnt", cn1, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("L_oor_pc", pc1, 32'h4000);
        chk("L_oor_ia", {22'h0, ia1}, 32'h0);
        chk("L_oor_err0", {31'h0, e1}, 32'h0);
        redirect = 1'b0;
        step();
        chk("L_oor_err", {31'h0, e1}, 32'h1);
        step();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h2FFC;
        step();
        chk("L_wrap_ia", {22'h0, ia1}, 32'h3FF);
        redirect = 1'b0;
        step();
        chk("L_wrap_err", {31'h0, e0}, 32'h1);
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
